reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Reset controller for the flop-based datapath: takes the board reset (async assert), synchronises its release,
//  then deasserts NUM_STAGES downstream active-low resets one stage at a time, RELEASE_GAP cycles apart.
//  Also serves a four-phase soft-reset request that re-runs the staged sequence without a hard reset.
//  Sits at the top of each clock domain, driving the rst inputs of the async-reset flops.
// PARAMETERS
//  NUM_STAGES   4  number of sequenced reset outputs; stage 0 released first; >=1
//  SYNC_DEPTH   2  flops in the reset-release synchroniser; >=2
//  RELEASE_GAP  8  clk cycles between consecutive stage releases; 1..2**CNT_W-1
//  SOFT_HOLD    4  cycles all stages are held in reset on a soft reset; 1..2**CNT_W-1
//  CNT_W        8  width of the shared gap/hold counter
// PORTS
//  clk          in   1           clock
//  rst          in   1           asynchronous, active-low reset
//  soft_req     in   1           soft-reset request, level, four-phase with soft_ack
//  soft_ack     out  1           soft-reset complete; held until soft_req is sampled low
//  stage_rst_n  out  NUM_STAGES  sequenced active-low resets; bit k = stage k
//  ready        out  1           1 when every stage is released (state RUN)
//  state        out  2           debug: 0=HOLD 1=REL 2=RUN 3=SOFT
// BEHAVIOUR
//  - All flops use async active-low rst. While rst=0: stage_rst_n=0, ready=0, soft_ack=0, state=HOLD.
//    Cleared immediately, not at the next edge. Counter, stage index and sync chain are 0.
//  - Release sync: chain shifts in 1 per edge after rst rises; rst_sync=1 at edge SYNC_DEPTH.
//  - HOLD: all stages in reset. rst_sync=1 -> REL; cnt=0, idx=0.
//  - REL: cnt increments each edge. At cnt==RELEASE_GAP-1: set stage_rst_n[idx]=1, idx++, cnt=0.
//    Releasing idx==NUM_STAGES-1 enters RUN and sets ready=1 on the same edge.
//    Stage k releases RELEASE_GAP*(k+1) edges after REL entry. Released stages stay released.
//  - RUN: on an edge with soft_req=1 and soft_ack=0 -> SOFT. On that edge: stage_rst_n=all 0, ready=0, cnt=0.
//  - SOFT: all stages held for SOFT_HOLD edges, then -> REL with cnt=0, idx=0.
//    The sequence then repeats as after a hard reset.
//  - soft_ack: set to 1 on the edge that re-enters RUN from a soft-initiated REL (tracked by a soft_pending flag).
//    Cleared on the first edge where soft_req=0.
//    soft_req remaining 1 while soft_ack=1 never retriggers.
//  - soft_req outside RUN is not latched. It is acted on at the first RUN edge where it is still 1 and soft_ack=0.
//  - rst low at any time (including mid-REL or SOFT) aborts to HOLD with all outputs at reset values.
//    soft_pending is dropped, so no ack follows a hard reset.
//  - Stage outputs are registered, glitch-free, and change only on clk edges, except async assertion by rst.
// STRUCTURE
//  - Shared include rst_seq_defs.vh: state localparams HOLD/REL/RUN/SOFT (2-bit).
//    The same file holds the width rule CNT_W >= clog2(max(RELEASE_GAP,SOFT_HOLD)+1).
//  - Sub-module reset_sync: SYNC_DEPTH-flop async-assert/sync-deassert chain, reused by other domains.
//  - Top: FSM, one shared CNT_W counter, idx register of clog2(NUM_STAGES)+1 bits, stage_rst_n register.
// TESTING
//  1. Power-up, defaults: rst=0 for 3 cycles, then 1 (edge 0 = first edge with rst=1).
//     stage_rst_n=0000 until edge 11, 0001@11, 0011@19, 0111@27, 1111@35. ready=1 and state=2 @35.
//  2. Mid-release abort: drop rst between edges while stage_rst_n=0011.
//     stage_rst_n=0000, ready=0, state=0 before the next edge. On rst release, test 1 timing restarts from edge 0.
//  3. Soft reset: in RUN, soft_req=1 sampled at edge E -> stage_rst_n=0000, ready=0, state=3 @E.
//     state=1 @E+4; 0001@E+12 ... 1111@E+36; soft_ack=1 and ready=1 @E+36.
//     soft_req=0 at edge F -> soft_ack=0 @F.
//  4. Held request: keep soft_req=1 for 20 cycles after soft_ack=1 -> no second sequence, stage_rst_n stays 1111.
//     After the ack drops, a new request starts a new sequence.
//  5. Early request: soft_req=1 throughout power-up -> ready=1 @35, then SOFT entered @36 (one RUN cycle).
//     soft_ack=1 @72.
//  6. NUM_STAGES=1, RELEASE_GAP=1, SOFT_HOLD=1: rst rises -> stage_rst_n=1 and ready=1 @4.
//     A soft_req gives a 1-cycle hold, release 2 edges after the request edge.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state encoding and counter width rule for the reset sequencer
package reset_sequencer_pkg;

   // Debug-visible sequencer states; the encoding is exported on the state port.
   typedef enum logic [1:0] {
      HOLD = 2'd0,
      REL  = 2'd1,
      RUN  = 2'd2,
      SOFT = 2'd3
   } seq_state_t;

   // Smallest shared counter width able to reach both the release gap and the soft hold:
   // CNT_W must be >= clog2(max(RELEASE_GAP, SOFT_HOLD) + 1).
   function automatic int min_cnt_w(input int gap, input int hold);
      int m;
      m = (gap > hold) ? gap : hold;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// rtl/reset_sequencer_sync.sv - async-assert / sync-deassert reset release synchroniser
module reset_sync #(
   parameter int SYNC_DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   output logic rst_sync
);

   logic [SYNC_DEPTH-1:0] chain;
   logic                  out_q;

   // Shift ones in after release; the final output flop keeps the FSM fanout off the
   // synchroniser's last stage, so rst_sync rises SYNC_DEPTH edges after edge 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain <= '0;
         out_q <= 1'b0;
      end else begin
         chain <= {chain[SYNC_DEPTH-2:0], 1'b1};
         out_q <= chain[SYNC_DEPTH-1];
      end
   end

   assign rst_sync = out_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release controller with four-phase soft reset
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int SYNC_DEPTH  = 2,
   parameter int RELEASE_GAP = 8,
   parameter int SOFT_HOLD   = 4,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  soft_req,
   output logic                  soft_ack,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  ready,
   output logic [1:0]            state
);

   localparam int IDX_W = $clog2(NUM_STAGES) + 1;
   localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(RELEASE_GAP - 1);
   localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(SOFT_HOLD - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   seq_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic                  ready_q, ready_d;
   logic                  ack_q, ack_d;
   logic                  pend_q, pend_d;
   logic                  enter_run;
   logic                  rst_sync;

   reset_sync #(
      .SYNC_DEPTH(SYNC_DEPTH)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .rst_sync (rst_sync)
   );

   // Next-state, counter, stage and handshake decisions for one clock edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      stage_d   = stage_q;
      ready_d   = ready_q;
      pend_d    = pend_q;
      ack_d     = ack_q;
      enter_run = 1'b0;

      case (state_q)
         HOLD: begin
            stage_d = '0;
            ready_d = 1'b0;
            if (rst_sync) begin
               state_d = REL;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         REL: begin
            if (cnt_q == GAP_END) begin
               cnt_d = '0;
               for (int k = 0; k < NUM_STAGES; k++) begin
                  if (idx_q == IDX_W'(k)) begin
                     stage_d[k] = 1'b1;
                  end
               end
               idx_d = idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d   = RUN;
                  ready_d   = 1'b1;
                  enter_run = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            // An acknowledged request still held high must not start another sequence.
            if (soft_req && !ack_q) begin
               state_d = SOFT;
               stage_d = '0;
               ready_d = 1'b0;
               cnt_d   = '0;
               pend_d  = 1'b1;
            end
         end
         SOFT: begin
            if (cnt_q == HOLD_END) begin
               state_d = REL;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = HOLD;
         end
      endcase

      // Ack on completing a soft-initiated sequence; drop it once the requester lets go.
      if (enter_run && pend_q) begin
         ack_d  = 1'b1;
         pend_d = 1'b0;
      end else if (!soft_req) begin
         ack_d = 1'b0;
      end
   end

   // Sequencer registers; rst forces every output to its reset value without waiting for clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         stage_q <= '0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stage_q <= stage_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
         pend_q  <= pend_d;
      end
   end

   assign stage_rst_n = stage_q;
   assign ready       = ready_q;
   assign soft_ack    = ack_q;
   assign state       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer against a timeline model
module tb_reset_sequencer;

   localparam int SD = 2;
   localparam int P_WAIT = 0, P_REL = 1, P_RUN = 2, P_SOFT = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, req0, ack0, rdy0;
   logic [3:0] stg0;
   logic [1:0] st0;
   logic       rst1, req1, ack1, rdy1;
   logic [0:0] stg1;
   logic [1:0] st1;

   reset_sequencer #(
      .NUM_STAGES(4), .SYNC_DEPTH(SD), .RELEASE_GAP(8), .SOFT_HOLD(4), .CNT_W(8)
   ) u0 (
      .clk(clk), .rst(rst0), .soft_req(req0), .soft_ack(ack0),
      .stage_rst_n(stg0), .ready(rdy0), .state(st0)
   );

   reset_sequencer #(
      .NUM_STAGES(1), .SYNC_DEPTH(SD), .RELEASE_GAP(1), .SOFT_HOLD(1), .CNT_W(8)
   ) u1 (
      .clk(clk), .rst(rst1), .soft_req(req1), .soft_ack(ack1),
      .stage_rst_n(stg1), .ready(rdy1), .state(st1)
   );

   int checks = 0;
   int errors = 0;

   // Timeline model: edges since rst rose, and the edge at which each phase began.
   int ph[2], e[2], rs[2], ss[2];
   bit pend[2], ackm[2];
   int ns[2]   = '{4, 1};
   int gap[2]  = '{8, 1};
   int hold[2] = '{4, 1};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_stage(input int i);
      int n;
      if (ph[i] == P_REL) begin
         n = (e[i] - rs[i]) / gap[i];
         if (n > ns[i]) n = ns[i];
         return 4'((1 << n) - 1);
      end else if (ph[i] == P_RUN) begin
         return 4'((1 << ns[i]) - 1);
      end
      return 4'b0;
   endfunction

   task automatic model_reset(input int i);
      ph[i] = P_WAIT; e[i] = -1; rs[i] = 0; ss[i] = 0; pend[i] = 0; ackm[i] = 0;
   endtask

   task automatic model_edge(input int i, input bit r, input bit q);
      bit old_ack, set_now;
      if (!r) return;
      e[i]++;
      old_ack = ackm[i];
      set_now = 0;
      case (ph[i])
         P_WAIT: if (e[i] == SD + 1) begin ph[i] = P_REL; rs[i] = e[i]; end
         P_REL: if ((e[i] - rs[i]) / gap[i] >= ns[i]) begin
            ph[i] = P_RUN;
            if (pend[i]) begin ackm[i] = 1; pend[i] = 0; set_now = 1; end
         end
         P_RUN: if (q && !old_ack) begin ph[i] = P_SOFT; ss[i] = e[i]; pend[i] = 1; end
         default: if (e[i] - ss[i] == hold[i]) begin ph[i] = P_REL; rs[i] = e[i]; end
      endcase
      if (!set_now && !q) ackm[i] = 0;
   endtask

   task automatic check_dut(input int i);
      logic [3:0] os;
      logic       ordy, oack;
      logic [1:0] ost;
      os   = (i == 0) ? stg0 : {3'b0, stg1};
      ordy = (i == 0) ? rdy0 : rdy1;
      oack = (i == 0) ? ack0 : ack1;
      ost  = (i == 0) ? st0 : st1;
      check($sformatf("d%0d_stage_e%0d", i, e[i]), os, exp_stage(i));
      check($sformatf("d%0d_ready_e%0d", i, e[i]), ordy, (ph[i] == P_RUN));
      check($sformatf("d%0d_state_e%0d", i, e[i]), ost, ph[i]);
      check($sformatf("d%0d_ack_e%0d", i, e[i]), oack, ackm[i]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(0, rst0, req0);
      model_edge(1, rst1, req1);
      #1;
      check_dut(0);
      check_dut(1);
   endtask

   task automatic hard_drop(input int i);
      if (i == 0) rst0 = 1'b0; else rst1 = 1'b0;
      #1;
      model_reset(i);
      check_dut(i);
   endtask

   initial begin
      int t_e, t_rdy, t_soft, t_ack, r;
      rst0 = 0; rst1 = 0; req0 = 0; req1 = 0;
      model_reset(0);
      model_reset(1);
      #1;
      check_dut(0);
      check_dut(1);

      // Power-up with defaults.
      repeat (3) tick();
      rst0 = 1;
      repeat (36) begin
         tick();
         case (e[0])
            10: check("pwr_stage10", stg0, 4'b0000);
            11: check("pwr_stage11", stg0, 4'b0001);
            19: check("pwr_stage19", stg0, 4'b0011);
            27: check("pwr_stage27", stg0, 4'b0111);
            34: check("pwr_ready34", rdy0, 1'b0);
            35: begin
               check("pwr_stage35", stg0, 4'b1111);
               check("pwr_ready35", rdy0, 1'b1);
               check("pwr_state35", st0, 2'd2);
            end
            default: ;
         endcase
      end

      // Mid-release abort, then a full restart.
      hard_drop(0);
      repeat (2) tick();
      rst0 = 1;
      for (int k = 0; k < 40 && exp_stage(0) != 4'b0011; k++) tick();
      repeat ($urandom_range(0, 5)) tick();
      hard_drop(0);
      check("abort_stage", stg0, 4'b0000);
      check("abort_state", st0, 2'd0);
      repeat (2) tick();
      rst0 = 1;
      repeat (36) begin
         tick();
         if (e[0] == 11) check("restart_stage11", stg0, 4'b0001);
         if (e[0] == 35) check("restart_ready35", rdy0, 1'b1);
      end

      // Soft reset with random lead-in and random release of the request.
      repeat ($urandom_range(1, 5)) tick();
      req0 = 1;
      tick();
      t_e = e[0];
      check("soft_state_E", st0, 2'd3);
      t_ack = -1;
      for (int k = 0; k < 60 && t_ack < 0; k++) begin
         tick();
         if (e[0] == t_e + 4) check("soft_rel_E4", st0, 2'd1);
         if (e[0] == t_e + 12) check("soft_stage_E12", stg0, 4'b0001);
         if (ack0 === 1'b1) t_ack = e[0];
      end
      check("soft_ack_edge", t_ack - t_e, 36);
      check("soft_ready_ack", rdy0, 1'b1);

      // Held request: no retrigger while acked.
      repeat (20) begin
         tick();
         check("held_stage", stg0, 4'b1111);
      end
      req0 = 0;
      tick();
      check("ack_drop", ack0, 1'b0);
      tick();
      req0 = 1;
      tick();
      check("second_soft", st0, 2'd3);
      for (int k = 0; k < 60 && ack0 !== 1'b1; k++) tick();
      check("second_ack", ack0, 1'b1);
      req0 = 0;
      tick();

      // Early request held through power-up.
      hard_drop(0);
      req0 = 1;
      repeat (2) tick();
      rst0 = 1;
      t_rdy = -1; t_soft = -1; t_ack = -1;
      repeat (80) begin
         tick();
         if (t_rdy < 0 && rdy0 === 1'b1) t_rdy = e[0];
         if (t_soft < 0 && st0 === 2'd3) t_soft = e[0];
         if (t_ack < 0 && ack0 === 1'b1) t_ack = e[0];
      end
      check("early_ready", t_rdy, 35);
      check("early_soft", t_soft, 36);
      check("early_ack", t_ack, 72);
      req0 = 0;
      tick();

      // Minimal configuration: one stage, gap 1, hold 1.
      rst1 = 1;
      repeat (6) begin
         tick();
         if (e[1] == 3) check("min_ready3", rdy1, 1'b0);
         if (e[1] == 4) begin
            check("min_stage4", stg1, 1'b1);
            check("min_ready4", rdy1, 1'b1);
         end
      end
      req1 = 1;
      tick();
      check("min_soft_E", st1, 2'd3);
      tick();
      check("min_rel_E1", st1, 2'd1);
      tick();
      check("min_stage_E2", stg1, 1'b1);
      check("min_ack_E2", ack1, 1'b1);
      req1 = 0;
      tick();

      // Random request toggling and occasional hard aborts on both instances.
      repeat (400) begin
         r = $urandom_range(0, 39);
         if (r == 0) begin
            hard_drop(0);
            repeat ($urandom_range(1, 3)) tick();
            rst0 = 1;
         end else if (r == 1) begin
            hard_drop(1);
            repeat ($urandom_range(1, 3)) tick();
            rst1 = 1;
         end else if (r < 10) begin
            req0 = ~req0;
         end else if (r < 16) begin
            req1 = ~req1;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
